pwm_capture: RTL

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 73 +++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input,
// flagging loss of edges with the stuck level.
module pwm_capture #(
   parameter int TIMEOUT = 2000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        pwm_in,
   output logic [10:0] period_cnt,
   output logic [10:0] high_cnt,
   output logic        valid,
   output logic        timeout,
   output logic        level
);
   typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
   state_t state, state_nx;
   logic s1, s2, s3;
   logic [10:0] cnt, hacc;
   logic rise, lost;
   assign rise = s2 & ~s3;
   // an edge in the same cycle as the limit takes priority over timing out
   assign lost = (state == MEAS) && !rise && (cnt == 11'(TIMEOUT));
   always_ff @(posedge clk or posedge rst)
      if (rst) {s1, s2, s3} <= 3'b000;
      else {s1, s2, s3} <= {pwm_in, s1, s2};
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      state_nx = !en ? IDLE :
                 (state == IDLE) ? ARM :
                 (state == ARM) ? (rise ? MEAS : ARM) :
                 (lost ? ARM : MEAS);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt        <= '0;
         hacc       <= '0;
         period_cnt <= '0;
         high_cnt   <= '0;
         valid      <= 1'b0;
         timeout    <= 1'b0;
         level      <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (!en || state == IDLE) begin
            cnt  <= '0;
            hacc <= '0;
         end else if (state == ARM) begin
            if (rise) begin
               cnt  <= 11'd1;
               hacc <= 11'd1;
            end
         end else if (rise) begin
            period_cnt <= cnt;
            high_cnt   <= hacc;
            valid      <= 1'b1;
            timeout    <= 1'b0;
            cnt        <= 11'd1;
            hacc       <= 11'd1;
         end else if (lost) begin
            timeout <= 1'b1;
            level   <= s2;
            cnt     <= '0;
            hacc    <= '0;
         end else begin
            cnt  <= cnt + 11'd1;
            hacc <= hacc + 11'(s2);
         end
      end
endmodule
